// File: rtl/des_io_pkg.sv
// rtl/des_io_pkg.sv - shared states, command bits and byte-lane helper for the DES pad sequencer
package des_io_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_KEY  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_RUN  = 3'd3;
    localparam state_t ST_EMIT = 3'd4;

    localparam int CMD_DECRYPT     = 0;
    localparam int CMD_REUSE_KEY   = 1;
    localparam int BYTES_PER_BLOCK = 8;

    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_BLOCK - 1);

    // Bit offset of byte lane n inside a 64-bit block (lane 0 = bits 7:0).
    function automatic logic [5:0] byte_lsb(input logic [2:0] n);
        return {n, 3'b000};
    endfunction

endpackage

// File: rtl/des_io_sync2.sv
// rtl/des_io_sync2.sv - two-flop synchronizer for a single asynchronous level
module des_io_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/des_io_sequencer.sv
// rtl/des_io_sequencer.sv - pad byte handshake that loads key/data, runs the DES core and emits the result
module des_io_sequencer
    import des_io_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        io_req_i,
    input  logic [7:0]  io_data_i,
    output logic        io_ack_o,
    output logic [7:0]  io_out_o,
    output logic        out_valid_o,
    output logic        busy_o,
    output logic [63:0] des_key_o,
    output logic [63:0] des_data_o,
    output logic        des_decrypt_o,
    output logic        des_start_o,
    input  logic        des_done_i,
    input  logic [63:0] des_result_i
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic        req_s;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        key_valid_q, key_valid_d;
    logic        ack_q, ack_d;
    logic [7:0]  out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic        decrypt_q, decrypt_d;
    logic [63:0] key_q, key_d;
    logic [63:0] data_q, data_d;
    logic [63:0] res_q, res_d;
    logic        accepting;
    logic        take;

    des_io_sync2 u_req_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (io_req_i),
        .q   (req_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        key_valid_d = key_valid_q;
        ack_d       = ack_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        start_d     = 1'b0;
        decrypt_d   = decrypt_q;
        key_d       = key_q;
        data_d      = data_q;
        res_d       = res_q;

        accepting = (state_q == ST_IDLE) || (state_q == ST_KEY) || (state_q == ST_DATA);
        take      = accepting && req_s && !ack_q;

        // The last data byte's ack may still be up in RUN; it only ever falls there.
        if (!req_s) begin
            ack_d = 1'b0;
        end else if (take) begin
            ack_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    decrypt_d = io_data_i[CMD_DECRYPT];
                    cnt_d     = 3'd0;
                    state_d   = (io_data_i[CMD_REUSE_KEY] && key_valid_q) ? ST_DATA : ST_KEY;
                end
            end
            ST_KEY: begin
                if (take) begin
                    key_d[byte_lsb(~cnt_q) +: 8] = io_data_i;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LAST_BYTE) begin
                        key_valid_d = 1'b1;
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (take) begin
                    data_d[byte_lsb(~cnt_q) +: 8] = io_data_i;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LAST_BYTE) begin
                        start_d = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (des_done_i) begin
                    res_d       = des_result_i;
                    out_d       = des_result_i[7:0];
                    out_valid_d = 1'b1;
                    hold_d      = 8'd0;
                    cnt_d       = 3'd0;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = 8'd0;
                    if (cnt_q == LAST_BYTE) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        out_d = res_q[byte_lsb(cnt_q + 3'd1) +: 8];
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            hold_q      <= 8'd0;
            key_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            decrypt_q   <= 1'b0;
            key_q       <= 64'd0;
            data_q      <= 64'd0;
            res_q       <= 64'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            key_valid_q <= key_valid_d;
            ack_q       <= ack_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            decrypt_q   <= decrypt_d;
            key_q       <= key_d;
            data_q      <= data_d;
            res_q       <= res_d;
        end
    end

    assign io_ack_o      = ack_q;
    assign io_out_o      = out_q;
    assign out_valid_o   = out_valid_q;
    assign busy_o        = busy_q;
    assign des_key_o     = key_q;
    assign des_data_o    = data_q;
    assign des_decrypt_o = decrypt_q;
    assign des_start_o   = start_q;

endmodule

// File: tb/tb_des_io_sequencer.sv
// tb/tb_des_io_sequencer.sv - directed vectors and corner sequences for des_io_sequencer
module tb_des_io_sequencer;

    typedef struct {
        logic [7:0]  cmd;
        bit          send_key;
        logic [63:0] key;
        logic [63:0] data;
        logic [63:0] result;
        logic [63:0] exp_key;
        logic        exp_dec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_req_i = 1'b0;
    logic [7:0]  io_data_i = 8'h00;
    logic        io_ack_o;
    logic [7:0]  io_out_o;
    logic        out_valid_o;
    logic        busy_o;
    logic [63:0] des_key_o;
    logic [63:0] des_data_o;
    logic        des_decrypt_o;
    logic        des_start_o;
    logic        stub_done = 1'b0;
    logic        man_done = 1'b0;
    logic        des_done_i;
    logic [63:0] stub_result = 64'd0;
    logic [63:0] des_result_i;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int stable_err = 0;

    vec_t vt[4];

    assign des_done_i   = stub_done | man_done;
    assign des_result_i = stub_result;

    always #5 clk = ~clk;

    des_io_sequencer #(.HOLD_CYCLES(16)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .io_req_i      (io_req_i),
        .io_data_i     (io_data_i),
        .io_ack_o      (io_ack_o),
        .io_out_o      (io_out_o),
        .out_valid_o   (out_valid_o),
        .busy_o        (busy_o),
        .des_key_o     (des_key_o),
        .des_data_o    (des_data_o),
        .des_decrypt_o (des_decrypt_o),
        .des_start_o   (des_start_o),
        .des_done_i    (des_done_i),
        .des_result_i  (des_result_i)
    );

    // DES core stub: done 16 cycles after start; operands must not move meanwhile.
    initial begin
        logic [63:0] k, d;
        logic        dec;
        forever begin
            @(negedge clk);
            if (des_start_o === 1'b1) begin
                starts++;
                k = des_key_o; d = des_data_o; dec = des_decrypt_o;
                for (int i = 0; i < 15; i++) begin
                    @(negedge clk);
                    if (des_key_o !== k || des_data_o !== d || des_decrypt_o !== dec || des_start_o !== 1'b0)
                        stable_err++;
                end
                stub_done = 1'b1;
                @(negedge clk);
                stub_done = 1'b0;
            end
        end
    end

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string nm);
        int n;
        io_data_i = b;
        io_req_i  = 1'b1;
        n = 0;
        while (io_ack_o !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        check64($sformatf("%s ack_rise byte %h", nm, b), {63'd0, io_ack_o}, 64'd1);
        io_req_i = 1'b0;
        n = 0;
        while (io_ack_o !== 1'b0 && n < 600) begin @(negedge clk); n++; end
        check64($sformatf("%s ack_fall byte %h", nm, b), {63'd0, io_ack_o}, 64'd0);
    endtask

    task automatic send_block(input logic [63:0] blk, input string nm);
        for (int i = 0; i < 8; i++)
            send_byte(blk[63 - 8*i -: 8], nm);
    endtask

    task automatic collect_emit(input logic [63:0] exp, input string nm);
        int n, bad;
        logic [7:0] eb, seen;
        n = 0;
        while (out_valid_o !== 1'b1 && n < 800) begin @(negedge clk); n++; end
        check64({nm, " valid_rise"}, {63'd0, out_valid_o}, 64'd1);
        for (int k = 0; k < 8; k++) begin
            eb = exp[8*k +: 8];
            bad = 0;
            seen = io_out_o;
            for (int c = 0; c < 16; c++) begin
                if (out_valid_o !== 1'b1 || io_out_o !== eb) begin
                    bad++;
                    seen = io_out_o;
                end
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL %s out_byte%0d actual=%h expected=%h bad_cycles=%0d", nm, k, seen, eb, bad);
            end
        end
        check64({nm, " valid_fall"}, {63'd0, out_valid_o}, 64'd0);
        check64({nm, " out_last"}, {56'd0, io_out_o}, {56'd0, exp[63:56]});
        check64({nm, " busy_end"}, {63'd0, busy_o}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit skip_cmd, input string nm);
        int s0, e0;
        stub_result = v.result;
        s0 = starts;
        e0 = stable_err;
        if (!skip_cmd) send_byte(v.cmd, nm);
        if (v.send_key) send_block(v.key, nm);
        send_block(v.data, nm);
        check64({nm, " key"}, des_key_o, v.exp_key);
        check64({nm, " data"}, des_data_o, v.data);
        check64({nm, " decrypt"}, {63'd0, des_decrypt_o}, {63'd0, v.exp_dec});
        check64({nm, " busy_run"}, {63'd0, busy_o}, 64'd1);
        check64({nm, " start_count"}, 64'(starts - s0), 64'd1);
        collect_emit(v.result, nm);
        check64({nm, " stable_run"}, 64'(stable_err - e0), 64'd0);
        check64({nm, " start_count_end"}, 64'(starts - s0), 64'd1);
    endtask

    initial begin
        int n, acks, bad;

        vt[0] = '{8'h00, 1'b1, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF,
                  64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0};
        vt[1] = '{8'h03, 1'b0, 64'h0, 64'hFEDCBA9876543210,
                  64'h0011223344556677, 64'h133457799BBCDFF1, 1'b1};
        vt[2] = '{8'h01, 1'b1, 64'h0E329232EA6D0D73, 64'h8787878787878787,
                  64'hA5A55A5A01020304, 64'h0E329232EA6D0D73, 1'b1};
        vt[3] = '{8'hFE, 1'b0, 64'h0, 64'h0102030405060708,
                  64'h1122334455667788, 64'h0E329232EA6D0D73, 1'b0};

        // Reset values; the command byte is already requested while reset is held.
        io_data_i = 8'h02;
        io_req_i  = 1'b1;
        repeat (3) @(negedge clk);
        check64("rst ack", {63'd0, io_ack_o}, 64'd0);
        check64("rst out", {56'd0, io_out_o}, 64'd0);
        check64("rst valid", {63'd0, out_valid_o}, 64'd0);
        check64("rst busy", {63'd0, busy_o}, 64'd0);
        check64("rst start", {63'd0, des_start_o}, 64'd0);
        check64("rst key", des_key_o, 64'd0);
        check64("rst data", des_data_o, 64'd0);
        check64("rst dec", {63'd0, des_decrypt_o}, 64'd0);
        rst = 1'b0;

        // Request high at release is a command; reuse without a valid key goes to KEY.
        n = 0;
        while (io_ack_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check64("held_req ack", {63'd0, io_ack_o}, 64'd1);
        io_req_i = 1'b0;
        n = 0;
        while (io_ack_o !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        run_vec('{8'h02, 1'b1, 64'hAABBCCDDEEFF0011, 64'h2233445566778899,
                  64'h0F1E2D3C4B5A6978, 64'hAABBCCDDEEFF0011, 1'b0}, 1'b1, "reuse_nokey");

        for (int i = 0; i < 4; i++)
            run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));

        // A request arriving during EMIT waits until IDLE, then decodes as a command.
        stub_result = vt[0].result;
        send_byte(8'h00, "emit_req");
        send_block(vt[0].key, "emit_req");
        send_block(vt[0].data, "emit_req");
        n = 0;
        while (out_valid_o !== 1'b1 && n < 800) begin @(negedge clk); n++; end
        io_data_i = 8'h03;
        io_req_i  = 1'b1;
        acks = 0;
        n = 0;
        while (busy_o === 1'b1 && n < 400) begin
            if (io_ack_o !== 1'b0) acks++;
            @(negedge clk);
            n++;
        end
        check64("emit_req ack_during_emit", 64'(acks), 64'd0);
        check64("emit_req idle", {63'd0, busy_o}, 64'd0);
        n = 0;
        while (io_ack_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check64("emit_req ack_in_idle", {63'd0, io_ack_o}, 64'd1);
        io_req_i = 1'b0;
        n = 0;
        while (io_ack_o !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        run_vec(vt[1], 1'b1, "emit_req_cmd");

        // Reset mid-key with ack raised, then a full fresh transfer.
        send_byte(8'h01, "midrst");
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), "midrst");
        io_data_i = 8'h14;
        io_req_i  = 1'b1;
        n = 0;
        while (io_ack_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check64("midrst ack_before", {63'd0, io_ack_o}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check64("midrst ack", {63'd0, io_ack_o}, 64'd0);
        check64("midrst out", {56'd0, io_out_o}, 64'd0);
        check64("midrst busy", {63'd0, busy_o}, 64'd0);
        check64("midrst dec", {63'd0, des_decrypt_o}, 64'd0);
        check64("midrst key", des_key_o, 64'd0);
        check64("midrst data", des_data_o, 64'd0);
        check64("midrst valid", {63'd0, out_valid_o}, 64'd0);
        check64("midrst start", {63'd0, des_start_o}, 64'd0);
        io_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vt[0], 1'b0, "after_rst");

        // Stray done pulses in IDLE and KEY are ignored.
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy_o !== 1'b0 || out_valid_o !== 1'b0) bad++;
            @(negedge clk);
        end
        check64("stray_done idle", 64'(bad), 64'd0);
        send_byte(8'h00, "stray_done");
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy_o !== 1'b1 || out_valid_o !== 1'b0) bad++;
            @(negedge clk);
        end
        check64("stray_done key", 64'(bad), 64'd0);
        run_vec('{8'h00, 1'b1, 64'h0102040810204080, 64'hFFEEDDCCBBAA9988,
                  64'h7766554433221100, 64'h0102040810204080, 1'b0}, 1'b1, "stray_done_txn");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_io_sequencer.md
DES_IO_SEQUENCER -- requirements
Module: des_io_sequencer

Interface
REQ-001 HOLD_CYCLES, 16, clock cycles each result byte is held on io_out_o (legal range 2..255).
REQ-002 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 io_req_i  in  1  byte request from pad; asynchronous to wb_clk_i.
REQ-005 io_data_i  in  8  byte from pad; stable while io_req_i is high.
REQ-006 io_ack_o  out  1  four-phase acknowledge to pad.
REQ-007 io_out_o  out  8  result byte to pad.
REQ-008 out_valid_o  out  1  high while a result byte is being presented.
REQ-009 busy_o  out  1  high in any state other than IDLE.
REQ-010 des_key_o  out  64  key to DES core.
REQ-011 des_data_o  out  64  data block to DES core.
REQ-012 des_decrypt_o  out  1  1 = decrypt, 0 = encrypt.
REQ-013 des_start_o  out  1  one-cycle start pulse.
REQ-014 des_done_i  in  1  one-cycle completion pulse from DES core.
REQ-015 des_result_i  in  64  DES output; valid in the des_done_i cycle.

Function
REQ-016 io_req_i SHALL pass through a 2-flop synchronizer; only req_s (the synchronized value) is used.
REQ-017 Handshake: in IDLE/KEY/DATA, req_s=1 with io_ack_o=0 captures io_data_i and sets io_ack_o next cycle; req_s=0 clears io_ack_o next cycle; one byte per full four-phase cycle.
REQ-018 In RUN/EMIT, io_ack_o SHALL stay 0 and requests SHALL wait unacknowledged until the block returns to IDLE.
REQ-019 States: IDLE, KEY, DATA, RUN, EMIT; 3-bit byte counter cnt.
REQ-020 IDLE: a captured byte is the command: bit0 -> decrypt flag, bit1 -> reuse key, bits 7:2 ignored.
REQ-021 After the command: if reuse=1 and key_valid=1 -> DATA; otherwise -> KEY. cnt cleared.
REQ-022 KEY: byte n (n=0..7) loads des_key_o[63-8n:56-8n], MSB first; after byte 7, set key_valid and go to DATA.
REQ-023 DATA: same byte ordering into des_data_o; after byte 7 go to RUN.
REQ-024 RUN entry: des_start_o=1 for exactly one cycle; des_key_o, des_data_o and des_decrypt_o SHALL remain stable through RUN.
REQ-025 RUN: on des_done_i, latch des_result_i and go to EMIT; des_done_i outside RUN SHALL be ignored.
REQ-026 EMIT: present byte k=0..7 as des_result[8k+7:8k], LSB byte first, each for exactly HOLD_CYCLES cycles, with out_valid_o=1 throughout.
REQ-027 After byte 7 has been held: out_valid_o=0, io_out_o keeps its last value, go to IDLE.
REQ-028 busy_o SHALL be a registered decode of state != IDLE.

Reset
REQ-029 Asserting wb_rst_i at any time, including mid-transfer, SHALL immediately force: state IDLE, cnt 0, key_valid 0, synchronizer 0, io_ack_o 0, io_out_o 0x00, out_valid_o 0, busy_o 0, des_start_o 0, des_decrypt_o 0, des_key_o 0, des_data_o 0.
REQ-030 After reset release, a req_s already high SHALL be treated as a new command byte.

Structure
REQ-031 Package des_io_pkg SHALL hold the state enumeration, command bit positions (CMD_DECRYPT=0, CMD_REUSE_KEY=1) and BYTES_PER_BLOCK=8.
REQ-032 The synchronizer SHALL be sub-module des_io_sync2 (1-bit, 2-flop, async active-high reset to 0); all other logic SHALL be flat.

Verification (bench DES stub: des_done_i 16 cycles after start, result 0x85E813540F0AB405)
REQ-033 Cmd 0x00, key 13 34 57 79 9B BC DF F1, data 01 23 45 67 89 AB CD EF -> des_key_o=0x133457799BBCDFF1, des_data_o=0x0123456789ABCDEF, des_decrypt_o=0, single des_start_o pulse; io_out_o sequence 05 B4 0A 0F 54 13 E8 85, each held 16 cycles.
REQ-034 Then cmd 0x03 + 8 data bytes -> no KEY state, des_decrypt_o=1, des_key_o unchanged.
REQ-035 After reset, cmd 0x02 -> KEY state entered, because key_valid=0.
REQ-036 req raised during EMIT -> io_ack_o stays 0 until IDLE, then the byte is acknowledged and decoded as a command.
REQ-037 wb_rst_i asserted after key byte 4 with io_ack_o=1 -> all outputs at reset values in the same cycle; a fresh full sequence then completes correctly.
REQ-038 des_done_i pulsed in IDLE and in KEY -> no state change and no EMIT.
